// File: rtl/alu_matrix_sequencer.sv
// Job sequencer in front of the ALU matrix: accepts (opcode, length) commands and
// streams one element at a time through the ALU, returning results on a valid/ready port.
module alu_matrix_sequencer #(
    parameter int DATA_W  = 32,
    parameter int SEL_W   = 6,
    parameter int LEN_W   = 5,
    parameter int MAX_LEN = 16,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [SEL_W-1:0]  cmd_op,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [SEL_W-1:0]  alu_sel,
    output logic [DATA_W-1:0] alu_eleIn,
    input  logic [DATA_W-1:0] alu_eleOut,
    output logic              busy,
    output logic              done,
    output logic              err_len
);

    localparam int LAT_W = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] EMIT  = 2'd3;

    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE_LEN   = LEN_W'(1);
    localparam logic [LAT_W-1:0] LAT_INIT  = LAT_W'(ALU_LAT);
    localparam logic [LAT_W-1:0] ONE_LAT   = LAT_W'(1);

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic              live;
    logic [SEL_W-1:0]  op_q;
    logic [LEN_W-1:0]  rem;
    logic [LAT_W-1:0]  lat_cnt;
    logic [DATA_W-1:0] ele_in_q;
    logic [DATA_W-1:0] out_data_q;
    logic              done_q;
    logic              err_len_q;

    logic cmd_fire;
    logic len_ok;
    logic in_take;
    logic out_take;
    logic capture;

    // live keeps cmd_ready low while reset is held and for the first edge after release
    assign cmd_ready = live && (state == IDLE);
    assign in_ready  = (state == ISSUE);
    assign out_valid = (state == EMIT);
    assign out_last  = out_valid && (rem == ONE_LEN);
    assign busy      = (state != IDLE);
    assign alu_sel   = busy ? op_q : '0;
    assign alu_eleIn = ele_in_q;
    assign out_data  = out_data_q;
    assign done      = done_q;
    assign err_len   = err_len_q;

    assign cmd_fire = cmd_valid && cmd_ready;
    assign len_ok   = (cmd_len != '0) && (cmd_len <= MAX_LEN_V);
    // abort outranks a coincident element handshake, so gated versions drive the datapath
    assign in_take  = in_valid && in_ready && !abort;
    assign out_take = out_ready && out_valid && !abort;
    assign capture  = (state == WAIT) && (lat_cnt == ONE_LAT) && !abort;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cmd_fire && len_ok) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (in_valid) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (lat_cnt == ONE_LAT) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (out_ready) begin
                    state_next = (rem == ONE_LEN) ? IDLE : ISSUE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            live  <= 1'b0;
        end else begin
            state <= state_next;
            live  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q       <= '0;
            rem        <= '0;
            lat_cnt    <= '0;
            ele_in_q   <= '0;
            out_data_q <= '0;
            done_q     <= 1'b0;
            err_len_q  <= 1'b0;
        end else begin
            done_q    <= out_take && (rem == ONE_LEN);
            err_len_q <= cmd_fire && !len_ok;
            if (cmd_fire && len_ok) begin
                op_q <= cmd_op;
                rem  <= cmd_len;
            end
            if (in_take) begin
                ele_in_q <= in_data;
                lat_cnt  <= LAT_INIT;
            end else if ((state == WAIT) && (lat_cnt != '0)) begin
                lat_cnt <= lat_cnt - ONE_LAT;
            end
            if (capture) begin
                out_data_q <= alu_eleOut;
            end
            if (out_take) begin
                rem <= rem - ONE_LEN;
            end
        end
    end

endmodule

// File: tb/tb_alu_matrix_sequencer.sv
// Scoreboard bench for alu_matrix_sequencer using a stub ALU that adds the
// zero-extended opcode to the registered element input.
module tb_alu_matrix_sequencer;

    localparam int LIMIT = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_op;
    logic [4:0]  cmd_len;
    logic        abort;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic [5:0]  alu_sel;
    logic [31:0] alu_eleIn;
    logic [31:0] alu_eleOut;
    logic        busy;
    logic        done;
    logic        err_len;

    int errors = 0;
    int checks = 0;
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    assign alu_eleOut = alu_eleIn + 32'(alu_sel);

    alu_matrix_sequencer dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
        .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .alu_sel(alu_sel), .alu_eleIn(alu_eleIn), .alu_eleOut(alu_eleOut),
        .busy(busy), .done(done), .err_len(err_len)
    );

    // All drivers are entered and left on a falling edge.
    task automatic send_cmd(input logic [5:0] op, input logic [4:0] len, output int waits);
        cmd_op = op; cmd_len = len; cmd_valid = 1'b1; waits = 0;
        while (!cmd_ready && waits < LIMIT) begin
            @(negedge clk);
            waits++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic send_elem(input logic [31:0] d, output int waits);
        in_data = d; in_valid = 1'b1; waits = 0;
        while (!in_ready && waits < LIMIT) begin
            @(negedge clk);
            waits++;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic take_out(output logic got, output logic [31:0] d, output logic l, output int waits);
        waits = 0;
        while (!out_valid && waits < LIMIT) begin
            @(negedge clk);
            waits++;
        end
        got = out_valid; d = out_data; l = out_last;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [76:0] obs;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        obs = {cmd_ready, in_ready, out_valid, out_last, busy, done, err_len, alu_sel, alu_eleIn, out_data};
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %0h expected 0", obs);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: cmd_ready=%b busy=%b expected 1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_single();
        int w;
        logic got, l;
        logic [31:0] d;
        logic [32:0] e;
        send_cmd(6'd18, 5'd1, w);
        exp_q.push_back({1'b1, 32'd48});
        send_elem(32'd30, w);
        take_out(got, d, l, w);
        e = exp_q.pop_front();
        checks++;
        if ({got, l, d} !== {1'b1, e}) begin
            errors++;
            $display("[TB] FAIL single_result: got v=%b last=%b data=%0d expected last=%b data=%0d", got, l, d, e[32], e[31:0]);
        end
        checks++;
        if (done !== 1'b1 || cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_done: done=%b cmd_ready=%b expected 1/1", done, cmd_ready);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_pulse_width: done=%b expected 0", done);
        end
    endtask

    task automatic test_stream();
        int w_in, w_out;
        logic got, l;
        logic [31:0] d;
        logic [32:0] e;
        send_cmd(6'd1, 5'd4, w_in);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({(i == 3), 32'(10 * (i + 1) + 1)});
            send_elem(32'(10 * (i + 1)), w_in);
            take_out(got, d, l, w_out);
            e = exp_q.pop_front();
            checks++;
            if ({got, l, d} !== {1'b1, e}) begin
                errors++;
                $display("[TB] FAIL stream_elem%0d: got v=%b last=%b data=%0d expected last=%b data=%0d", i, got, l, d, e[32], e[31:0]);
            end
            checks++;
            if (w_in != 0 || w_out != 1) begin
                errors++;
                $display("[TB] FAIL stream_timing%0d: in_wait=%0d out_wait=%0d expected 0/1", i, w_in, w_out);
            end
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stream_done: done=%b expected 1", done);
        end
    endtask

    task automatic test_backpressure();
        int w;
        logic got, l;
        logic [31:0] d, d0;
        logic [32:0] e;
        send_cmd(6'd3, 5'd3, w);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({(i == 2), 32'(100 * (i + 1) + 3)});
            send_elem(32'(100 * (i + 1)), w);
            if (i == 1) begin
                w = 0;
                while (!out_valid && w < LIMIT) begin
                    @(negedge clk);
                    w++;
                end
                d0 = out_data;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    checks++;
                    if (out_valid !== 1'b1 || out_data !== d0 || in_ready !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL stall_hold%0d: v=%b data=%0d in_ready=%b expected 1/%0d/0", c, out_valid, out_data, in_ready, d0);
                    end
                end
            end
            take_out(got, d, l, w);
            e = exp_q.pop_front();
            checks++;
            if ({got, l, d} !== {1'b1, e}) begin
                errors++;
                $display("[TB] FAIL stall_elem%0d: got v=%b last=%b data=%0d expected last=%b data=%0d", i, got, l, d, e[32], e[31:0]);
            end
        end
    endtask

    task automatic test_bad_len();
        int w;
        logic [4:0] lens[2];
        lens[0] = 5'd0;
        lens[1] = 5'd17;
        for (int i = 0; i < 2; i++) begin
            send_cmd(6'd7, lens[i], w);
            checks++;
            if (err_len !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bad_len%0d: err_len=%b busy=%b in_ready=%b expected 1/0/0", lens[i], err_len, busy, in_ready);
            end
            @(negedge clk);
            checks++;
            if (err_len !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bad_len_pulse%0d: err_len=%b busy=%b expected 0/0", lens[i], err_len, busy);
            end
        end
        send_cmd(6'd7, 5'd16, w);
        checks++;
        if (err_len !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL max_len_accept: err_len=%b busy=%b expected 0/1", err_len, busy);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic test_abort();
        int w;
        logic got, l;
        logic [31:0] d;
        logic [32:0] e;
        send_cmd(6'd4, 5'd4, w);
        exp_q.push_back({1'b0, 32'd5});
        send_elem(32'd1, w);
        take_out(got, d, l, w);
        e = exp_q.pop_front();
        checks++;
        if ({got, l, d} !== {1'b1, e}) begin
            errors++;
            $display("[TB] FAIL abort_first: got v=%b last=%b data=%0d expected last=%b data=%0d", got, l, d, e[32], e[31:0]);
        end
        exp_q.push_back({1'b0, 32'd6});
        send_elem(32'd2, w);
        w = 0;
        while (!out_valid && w < LIMIT) begin
            @(negedge clk);
            w++;
        end
        abort = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        out_ready = 1'b0;
        void'(exp_q.pop_front());
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_idle: busy=%b v=%b done=%b cmd_ready=%b expected 0/0/0/1", busy, out_valid, done, cmd_ready);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_no_done: done=%b in_ready=%b expected 0/0", done, in_ready);
        end
        send_cmd(6'd2, 5'd1, w);
        exp_q.push_back({1'b1, 32'd7});
        send_elem(32'd5, w);
        take_out(got, d, l, w);
        e = exp_q.pop_front();
        checks++;
        if ({got, l, d, done} !== {1'b1, e, 1'b1}) begin
            errors++;
            $display("[TB] FAIL abort_next_job: got v=%b last=%b data=%0d done=%b expected last=%b data=%0d done=1", got, l, d, done, e[32], e[31:0]);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        logic got, l;
        logic [31:0] d;
        logic [32:0] e;
        send_cmd(6'd1, 5'd1, w);
        exp_q.push_back({1'b1, 32'd8});
        send_elem(32'd7, w);
        w = 0;
        while (!out_valid && w < LIMIT) begin
            @(negedge clk);
            w++;
        end
        cmd_op = 6'd3; cmd_len = 5'd1; cmd_valid = 1'b1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_ready_busy: cmd_ready=%b expected 0", cmd_ready);
        end
        take_out(got, d, l, w);
        e = exp_q.pop_front();
        checks++;
        if ({got, l, d} !== {1'b1, e}) begin
            errors++;
            $display("[TB] FAIL b2b_first: got v=%b last=%b data=%0d expected last=%b data=%0d", got, l, d, e[32], e[31:0]);
        end
        checks++;
        if (cmd_ready !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_idle_cycle: cmd_ready=%b done=%b expected 1/1", cmd_ready, done);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || alu_sel !== 6'd3) begin
            errors++;
            $display("[TB] FAIL b2b_accept: busy=%b in_ready=%b sel=%0d expected 1/1/3", busy, in_ready, alu_sel);
        end
        exp_q.push_back({1'b1, 32'd13});
        send_elem(32'd10, w);
        take_out(got, d, l, w);
        e = exp_q.pop_front();
        checks++;
        if ({got, l, d} !== {1'b1, e}) begin
            errors++;
            $display("[TB] FAIL b2b_second: got v=%b last=%b data=%0d expected last=%b data=%0d", got, l, d, e[32], e[31:0]);
        end
    endtask

    task automatic test_random();
        int w, len;
        logic [5:0] op;
        logic [31:0] v, d;
        logic got, l;
        logic [32:0] e;
        for (int j = 0; j < 5; j++) begin
            op = 6'($urandom_range(0, 63));
            len = $urandom_range(1, 16);
            send_cmd(op, 5'(len), w);
            for (int i = 0; i < len; i++) begin
                v = $urandom;
                exp_q.push_back({(i == len - 1), v + 32'(op)});
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send_elem(v, w);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                take_out(got, d, l, w);
                e = exp_q.pop_front();
                checks++;
                if ({got, l, d} !== {1'b1, e}) begin
                    errors++;
                    $display("[TB] FAIL rand_job%0d_elem%0d: got v=%b last=%b data=%0h expected last=%b data=%0h", j, i, got, l, d, e[32], e[31:0]);
                end
            end
            checks++;
            if (done !== 1'b1) begin
                errors++;
                $display("[TB] FAIL rand_done%0d: done=%b expected 1", j, done);
            end
        end
    endtask

    task automatic test_async_reset();
        int w;
        logic got, l;
        logic [31:0] d;
        logic [32:0] e;
        logic [76:0] obs;
        send_cmd(6'd9, 5'd1, w);
        exp_q.push_back({1'b1, 32'd59});
        send_elem(32'd50, w);
        #1 reset = 1'b0;
        #1;
        obs = {cmd_ready, in_ready, out_valid, out_last, busy, done, err_len, alu_sel, alu_eleIn, out_data};
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset: got %0h expected 0", obs);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send_cmd(6'd5, 5'd1, w);
        exp_q.push_back({1'b1, 32'd25});
        send_elem(32'd20, w);
        take_out(got, d, l, w);
        e = exp_q.pop_front();
        checks++;
        if ({got, l, d, done} !== {1'b1, e, 1'b1}) begin
            errors++;
            $display("[TB] FAIL post_reset_job: got v=%b last=%b data=%0d done=%b expected last=%b data=%0d done=1", got, l, d, done, e[32], e[31:0]);
        end
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0; abort = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_bad_len();
        test_abort();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
